seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the combinational 32-bit ALU.
- Operand width is generic.
- Add, sub, shift and logic ops complete in one cycle.
- Multiply and divide use an iterative shift-add / restoring-divide datapath instead of wide combinational logic.
- Sits between an issue stage and a result consumer, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- opcode  input  3  operation select
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- res  output  2*WIDTH  result
- ov  output  1  overflow/carry flag

Behaviour:
- Opcodes:
  - 000 add: res = {0, a+b}, ov = carry out.
  - 001 sub: res = {0, a-b}, ov = signed overflow, i.e. (a[MSB]!=b[MSB]) && (a[MSB]!=diff[MSB]).
  - 010 mul: res = unsigned a*b (2*WIDTH bits).
  - 011 div: res = {a%b, a/b}.
  - 100 srl: res = {0, a >> b[SHW-1:0]}.
  - 101 sll: res = {0, a << b[SHW-1:0]}.
  - 110 and: res = {0, a&b}.
  - 111 or: res = {0, a|b}.
  - ov = 0 for every opcode except 000 and 001.
- Divide by zero: res = 0, ov = 0. Takes the same latency as a normal divide; no exception.
- FSM states:
  - IDLE → DONE on accept of a single-cycle opcode; result is registered in that same edge.
  - IDLE → MUL on accept of 010; IDLE → DIV on accept of 011.
  - MUL/DIV → DONE after the final iteration. Default is WIDTH iterations, so the counter counts WIDTH-1 down to 0.
  - DONE → IDLE on out_ready.
- Accept occurs when in_valid && in_ready. in_ready = (state == IDLE).
- Operands and opcode are captured at accept. Input changes afterwards have no effect.
- Latency from the accept edge:
  - single-cycle ops: out_valid high on the next cycle;
  - mul/div: out_valid high WIDTH+1 cycles after accept.
- out_valid = (state == DONE).
- res and ov are held stable while out_valid && !out_ready.
- Throughput is one operation in flight. There is no bypass from DONE to a new accept in the same cycle.
- Multiply datapath:
  - product register, 2*WIDTH bits; a zero-extended; shifting multiplier register.
  - Each iteration: if the multiplier LSB is 1, add the shifted multiplicand. Then shift the multiplicand left and the multiplier right.
- Divide datapath (restoring):
  - remainder register WIDTH+1 bits; quotient register WIDTH bits.
  - Each iteration: shift {rem, quo} left by 1, trial-subtract b, restore if the result is negative, set the quotient LSB.
- Reset, including mid-operation:
  - state = IDLE, counter = 0, res = 0, ov = 0, out_valid = 0, in_ready = 1 while rst is high.
  - Any in-flight mul/div is discarded.
- in_valid while not IDLE is ignored; upstream must hold it.
- res and ov are registered outputs and keep their last value in IDLE.

Optional Feature:
SEQ_ALU_EARLY_TERM_EN
- Defined:
  - Multiply terminates once the remaining multiplier register is zero, checked after each iteration. Iteration count = max(1, index of highest set bit of b + 1).
  - Divide is unchanged.
  - Results are identical to the undefined case; only latency differs.
- Undefined: multiply always takes WIDTH iterations.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SRL, OP_SLL, OP_AND, OP_OR;
  - state enum: S_IDLE, S_MUL, S_DIV, S_DONE.
- One sub-module, seq_alu_iter, holds the shared iterative mul/div datapath and iteration counter. It has start, mode, done and a result port.
- The top level holds the FSM, the single-cycle ops and the output registers.

Test Plan:
All cases use WIDTH=32 unless stated.
- Add 0xFFFFFFFF + 0x1 → out_valid 1 cycle after accept, res = 0, ov = 1. Add 5 + 7 → res = 12, ov = 0.
- Sub 0x80000000 − 0x1 → res = 0x7FFFFFFF, ov = 1. Sub 3 − 5 → res low = 0xFFFFFFFE, ov = 0.
- Mul 0xFFFFFFFF × 0xFFFFFFFF → res = 0xFFFFFFFE00000001.
  - out_valid 33 cycles after accept; in_ready low for the whole operation.
  - With SEQ_ALU_EARLY_TERM_EN defined, 3 × 5 → res = 15, out_valid 4 cycles after accept.
- Div 100 / 7 → res = {32'd2, 32'd14}. Div 9 / 0 → res = 0, ov = 0, latency 33 cycles. Srl 0x80000000 by b = 33 → shift of 1 → 0x40000000.
- Backpressure: hold out_ready low for 5 cycles after out_valid.
  - res, ov and out_valid stay stable; in_ready stays low.
  - Pulse out_ready → next cycle in_ready = 1.
  - An in_valid held during DONE is accepted only after the return to IDLE.
- Assert rst asynchronously (mid-cycle) on the 10th cycle after accept of a mul.
  - out_valid = 0, res = 0 and in_ready = 1 immediately, without waiting for a clock edge.
  - After release, div 50 / 5 → res = {0, 10}.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus the mode select used by the iterative mul/div datapath.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SRL = 3'b100,
        OP_SLL = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath for multiply (shift-add) and divide (restoring).
// start loads operands; each following cycle performs one iteration. done is
// asserted combinationally during the final iteration and result carries that
// iteration's outcome, so the caller captures it on the same edge.
// SEQ_ALU_EARLY_TERM_EN: multiply stops once the remaining multiplier is zero.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int SHW = $clog2(WIDTH);

    // acc_q: product (mul) or remainder in the low WIDTH+1 bits (div).
    // opnd_q: shifting multiplicand (mul) or divisor (div).
    // sh_q: shifting multiplier (mul) or dividend/quotient (div).
    logic                 busy_q, busy_d;
    logic                 mode_q, mode_d;
    logic                 dz_q, dz_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]     sh_q, sh_d;

    logic [2*WIDTH-1:0]   mul_acc_n;
    logic [2*WIDTH-1:0]   mul_opnd_n;
    logic [WIDTH-1:0]     mul_sh_n;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       div_rem_n;
    logic [WIDTH-1:0]     div_quo_n;
    logic                 last;

    // One iteration of each algorithm, plus the final-iteration detect.
    always_comb begin
        mul_acc_n  = sh_q[0] ? (acc_q + opnd_q) : acc_q;
        mul_opnd_n = opnd_q << 1;
        mul_sh_n   = sh_q >> 1;

        rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd_q[WIDTH-1:0]};
        if (trial[WIDTH]) begin
            div_rem_n = rem_sh;
            div_quo_n = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            div_rem_n = trial;
            div_quo_n = {sh_q[WIDTH-2:0], 1'b1};
        end

        last = (cnt_q == '0);
`ifdef SEQ_ALU_EARLY_TERM_EN
        if ((mode_q == MODE_MUL) && (mul_sh_n == '0)) begin
            last = 1'b1;
        end
`endif

        done = busy_q && last;
        if (mode_q == MODE_DIV) begin
            result = dz_q ? '0 : {div_rem_n[WIDTH-1:0], div_quo_n};
        end else begin
            result = mul_acc_n;
        end
    end

    // Next-state for the datapath registers and iteration counter.
    always_comb begin
        busy_d = busy_q;
        mode_d = mode_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        sh_d   = sh_q;
        if (start) begin
            busy_d = 1'b1;
            mode_d = mode;
            dz_d   = (b == '0);
            cnt_d  = SHW'(WIDTH - 1);
            acc_d  = '0;
            if (mode == MODE_DIV) begin
                opnd_d = {{WIDTH{1'b0}}, b};
                sh_d   = a;
            end else begin
                opnd_d = {{WIDTH{1'b0}}, a};
                sh_d   = b;
            end
        end else if (busy_q) begin
            cnt_d = cnt_q - SHW'(1);
            if (mode_q == MODE_DIV) begin
                acc_d = {{(WIDTH-1){1'b0}}, div_rem_n};
                sh_d  = div_quo_n;
            end else begin
                acc_d  = mul_acc_n;
                opnd_d = mul_opnd_n;
                sh_d   = mul_sh_n;
            end
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            mode_q <= MODE_MUL;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            sh_q   <= sh_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on issue and result sides.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge. One operation is in
// flight at a time; in_ready is high only in IDLE, out_valid only in DONE, and
// res/ov are registered and held until the next result is captured.
// SEQ_ALU_EARLY_TERM_EN: shortens multiply latency for small multipliers.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           opcode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res,
    output logic                 ov
);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 ov_q, ov_d;

    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_ov;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;

    logic                 iter_start;
    logic                 iter_mode;
    logic                 iter_done;
    logic [2*WIDTH-1:0]   iter_result;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .mode   (iter_mode),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_result)
    );

    // Single-cycle operations, evaluated on the live inputs at accept.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        alu_res = '0;
        alu_ov  = 1'b0;
        case (op_e'(opcode))
            OP_ADD: begin
                alu_res = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                alu_ov  = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = {{WIDTH{1'b0}}, diff};
                alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (a[WIDTH-1] != diff[WIDTH-1]);
            end
            OP_SRL:  alu_res = {{WIDTH{1'b0}}, a >> b[SHW-1:0]};
            OP_SLL:  alu_res = {{WIDTH{1'b0}}, a << b[SHW-1:0]};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
            default: alu_res = '0;
        endcase
    end

    // FSM next-state and result capture.
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        ov_d       = ov_q;
        iter_start = 1'b0;
        iter_mode  = MODE_MUL;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (op_e'(opcode))
                        OP_MUL: begin
                            iter_start = 1'b1;
                            iter_mode  = MODE_MUL;
                            state_d    = S_MUL;
                        end
                        OP_DIV: begin
                            iter_start = 1'b1;
                            iter_mode  = MODE_DIV;
                            state_d    = S_DIV;
                        end
                        default: begin
                            res_d   = alu_res;
                            ov_d    = alu_ov;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (iter_done) begin
                    res_d   = iter_result;
                    ov_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign ov        = ov_q;

endmodule
